// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer.
// HEAD drives the decode side; SKID catches one extra word so in_ready
// never depends combinationally on out_ready.
module if_id_skid #(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned PC_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [PC_WIDTH-1:0]    in_pc4,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]    out_pc4,
   output logic [5:0]             out_opcode,
   output logic [4:0]             out_rs,
   output logic [4:0]             out_rt,
   output logic [4:0]             out_rd,
   output logic [15:0]            out_imm16,
   output logic [1:0]             count
);

   // Encoding equals occupancy so count falls straight out of the state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d;
   logic [PC_WIDTH-1:0]    head_pc4_q, head_pc4_d;
   logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
   logic [PC_WIDTH-1:0]    skid_pc4_q, skid_pc4_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [1:0]             count_q, count_d;
   logic                   accept;
   logic                   drain;

   // Next-state, buffer moves and registered handshake outputs.
   always_comb begin
      state_d      = state_q;
      head_instr_d = head_instr_q;
      head_pc4_d   = head_pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      accept       = in_valid & in_ready_q;
      drain        = out_valid_q & out_ready;

      if (flush) begin
         state_d      = ST_EMPTY;
         head_instr_d = '0;
         head_pc4_d   = '0;
         skid_instr_d = '0;
         skid_pc4_d   = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  head_instr_d = in_instr;
                  head_pc4_d   = in_pc4;
               end
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  state_d      = ST_TWO;
                  skid_instr_d = in_instr;
                  skid_pc4_d   = in_pc4;
               end else if (drain && !accept) begin
                  state_d = ST_EMPTY;
               end else if (accept && drain) begin
                  head_instr_d = in_instr;
                  head_pc4_d   = in_pc4;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state_d      = ST_ONE;
                  head_instr_d = skid_instr_q;
                  head_pc4_d   = skid_pc4_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
      count_d     = 2'(state_d);
   end

   // State and data registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         head_instr_q <= '0;
         head_pc4_q   <= '0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         head_instr_q <= head_instr_d;
         head_pc4_q   <= head_pc4_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         count_q      <= count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign count      = count_q;
   assign out_instr  = head_instr_q;
   assign out_pc4    = head_pc4_q;

   // Decode fields are plain slices of the head word.
   assign out_opcode = out_instr[31:26];
   assign out_rs     = out_instr[25:21];
   assign out_rt     = out_instr[20:16];
   assign out_rd     = out_instr[15:11];
   assign out_imm16  = out_instr[15:0];

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_id_skid;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc4 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic [15:0] out_imm16;
   logic [1:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   if_id_skid #(.INSTR_WIDTH(32), .PC_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
      .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_imm16(out_imm16), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: FIFO of (instr, pc4) pairs, depth 2, plus the last head value shown.
   typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } word_t;
   word_t       mq[$];
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc4   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_instr = '0;
         m_pc4   = '0;
      end else if (flush) begin
         mq.delete();
         m_instr = '0;
         m_pc4   = '0;
      end else begin
         bit   acc, drn;
         word_t w;
         acc = in_valid && (mq.size() < 2);
         drn = (mq.size() > 0) && out_ready;
         if (drn) void'(mq.pop_front());
         if (acc) begin
            w.instr = in_instr;
            w.pc4   = in_pc4;
            mq.push_back(w);
         end
         if (mq.size() > 0) begin
            m_instr = mq[0].instr;
            m_pc4   = mq[0].pc4;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [31:0] mi;
      mi = m_instr;
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() != 2));
      check("count", 64'(count), 64'(mq.size()));
      check("count_le2", 64'(count <= 2'd2), 64'd1);
      check("out_instr", 64'(out_instr), 64'(mi));
      check("out_pc4", 64'(out_pc4), 64'(m_pc4));
      check("out_opcode", 64'(out_opcode), 64'(mi[31:26]));
      check("out_rs", 64'(out_rs), 64'(mi[25:21]));
      check("out_rt", 64'(out_rt), 64'(mi[20:16]));
      check("out_rd", 64'(out_rd), 64'(mi[15:11]));
      check("out_imm16", 64'(out_imm16), 64'(mi[15:0]));
   end

   // Drive one cycle of inputs, returning just after the following negedge.
   task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic r, input logic f);
      in_valid  = v;
      in_instr  = i;
      in_pc4    = p;
      out_ready = r;
      flush     = f;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_pc4", 64'(out_pc4), 64'd0);
      rst = 1'b0;

      // Single word, field decode, then drain and hold
      cyc(1'b1, 32'h2008FFFC, 32'h4, 1'b1, 1'b0);
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_opcode", 64'(out_opcode), 64'h08);
      check("t1_rs", 64'(out_rs), 64'd0);
      check("t1_rt", 64'(out_rt), 64'd8);
      check("t1_rd", 64'(out_rd), 64'd31);
      check("t1_imm16", 64'(out_imm16), 64'hFFFC);
      check("t1_count", 64'(count), 64'd1);
      check("t1_pc4", 64'(out_pc4), 64'h4);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("t1_empty_valid", 64'(out_valid), 64'd0);
      check("t1_hold_instr", 64'(out_instr), 64'h2008FFFC);

      // Fill to two with stalled consumer, third push ignored, then drain in order
      cyc(1'b1, 32'h11111111, 32'h10, 1'b0, 1'b0);
      cyc(1'b1, 32'h22222222, 32'h14, 1'b0, 1'b0);
      check("t2_count2", 64'(count), 64'd2);
      check("t2_in_ready", 64'(in_ready), 64'd0);
      cyc(1'b1, 32'h33333333, 32'h18, 1'b0, 1'b0);
      check("t2_still2", 64'(count), 64'd2);
      check("t2_head", 64'(out_instr), 64'h11111111);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("t2_second", 64'(out_instr), 64'h22222222);
      check("t2_second_pc4", 64'(out_pc4), 64'h14);
      check("t2_count1", 64'(count), 64'd1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("t2_count0", 64'(count), 64'd0);

      // Simultaneous accept and drain at occupancy one
      cyc(1'b1, 32'h00000100, 32'h200, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b1, 32'h100 + 32'(k), 32'h200 + 32'(4 * k), 1'b1, 1'b0);
         check("t3_instr", 64'(out_instr), 64'(32'h100 + 32'(k)));
         check("t3_count", 64'(count), 64'd1);
      end
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush at occupancy two with a word offered
      cyc(1'b1, 32'hAAAA0001, 32'h30, 1'b0, 1'b0);
      cyc(1'b1, 32'hAAAA0002, 32'h34, 1'b0, 1'b0);
      cyc(1'b1, 32'h00000099, 32'h38, 1'b0, 1'b1);
      check("t4_count", 64'(count), 64'd0);
      check("t4_valid", 64'(out_valid), 64'd0);
      check("t4_instr", 64'(out_instr), 64'd0);
      check("t4_pc4", 64'(out_pc4), 64'd0);
      check("t4_in_ready", 64'(in_ready), 64'd1);

      // Asynchronous reset between edges at occupancy two
      cyc(1'b1, 32'hBBBB0001, 32'h40, 1'b0, 1'b0);
      cyc(1'b1, 32'hBBBB0002, 32'h44, 1'b0, 1'b0);
      check("t5_pre_count", 64'(count), 64'd2);
      in_valid = 1'b1;
      in_instr = 32'hDEADBEEF;
      #2 rst = 1'b1;
      #1;
      check("t5_async_count", 64'(count), 64'd0);
      check("t5_async_valid", 64'(out_valid), 64'd0);
      check("t5_async_ready", 64'(in_ready), 64'd1);
      check("t5_async_instr", 64'(out_instr), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("t5_no_accept_in_rst", 64'(count), 64'd0);
      rst = 1'b0;
      cyc(1'b1, 32'hABCD0001, 32'h50, 1'b0, 1'b0);
      check("t5_post_instr", 64'(out_instr), 64'hABCD0001);
      check("t5_post_count", 64'(count), 64'd1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Random traffic against the model
      for (int n = 0; n < 10000; n++) begin
         cyc(1'($urandom_range(0, 1)), $urandom, 32'(n * 4),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL provide parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL provide parameter PC_WIDTH, default 32, width of the PC+4 value.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  fetch stage presents a word.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_instr  input  INSTR_WIDTH  fetched instruction.
REQ-009 in_pc4  input  PC_WIDTH  PC+4 of the fetched instruction.
REQ-010 flush  input  1  synchronous discard of all buffered words (branch/jump taken).
REQ-011 out_valid  output  1  decode-side word valid.
REQ-012 out_ready  input  1  decode stage consumes the word this cycle.
REQ-013 out_instr  output  INSTR_WIDTH  head instruction.
REQ-014 out_pc4  output  PC_WIDTH  PC+4 of the head instruction.
REQ-015 out_opcode  output  6  out_instr[31:26].
REQ-016 out_rs, out_rt, out_rd  output  5 each  out_instr[25:21], [20:16], [15:11].
REQ-017 out_imm16  output  16  out_instr[15:0], feeds the 16->32 sign extender unmodified.
REQ-018 count  output  2  occupancy, 0..2.

Function
REQ-019 Storage SHALL be two entries, HEAD (drives out_*) and SKID, FIFO-ordered; state SHALL be EMPTY (count 0), ONE (1), TWO (2).
REQ-020 accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-021 in_ready SHALL equal (count != 2), decoded from registered state only, never from out_ready.
REQ-022 out_valid SHALL equal (count != 0).
REQ-023 EMPTY: accept -> ONE, word loaded into HEAD; else stay.
REQ-024 ONE: accept & !drain -> TWO, word into SKID; drain & !accept -> EMPTY; accept & drain -> ONE, new word into HEAD; neither -> stay.
REQ-025 TWO: in_ready = 0, so no accept; drain -> ONE, SKID moves to HEAD; else stay.
REQ-026 Latency SHALL be one cycle: a word accepted at edge N is on out_* with out_valid = 1 after edge N.
REQ-027 Pairing of instr and pc4 SHALL be preserved through every move; no word dropped or duplicated.
REQ-028 flush SHALL have priority over accept and drain: next state EMPTY, out_instr and out_pc4 cleared to 0 (NOP); a word presented in the flush cycle is discarded.
REQ-029 When count = 0 and no flush, out_instr/out_pc4 SHALL hold their last value.
REQ-030 Field outputs (REQ-015..017) SHALL be pure combinational slices of out_instr, with no added latency.
REQ-031 count SHALL never exceed 2 or wrap; in_valid while in_ready = 0 SHALL leave state unchanged.

Reset
REQ-032 rst = 1 SHALL asynchronously force count = 0, out_valid = 0, in_ready = 1, out_instr = 0, out_pc4 = 0, SKID = 0.
REQ-033 Reset asserted mid-operation (any state) SHALL discard all buffered words immediately; first accept after deassertion behaves as from EMPTY.
REQ-034 Deassertion SHALL be sampled on clk; no accept occurs in the cycle rst is high.

Verification
REQ-035 Reset then in_valid=1, in_instr=0x2008FFFC, in_pc4=0x4, out_ready=1 -> next cycle out_valid=1, out_opcode=0x08, out_rs=0, out_rt=8, out_imm16=0xFFFC, count=1.
REQ-036 out_ready=0, push 0x11111111 then 0x22222222 -> count=2, in_ready=0, third push ignored; release out_ready -> outputs 0x11111111 then 0x22222222 on consecutive cycles.
REQ-037 count=1, accept and drain same cycle for 10 cycles with incrementing words -> count stays 1, out_instr follows input delayed by exactly one cycle.
REQ-038 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=0, out_pc4=0, in_ready=1.
REQ-039 count=2, assert rst between clock edges -> outputs reach reset values without a clk edge; after release, push 0xABCD0001 -> appears with count=1.
REQ-040 Random in_valid/out_ready/flush for 10k cycles against a scoreboard -> order preserved, no loss or duplication outside flushes, count never >2.
